mem_trace_log_arbiter: RTL and testbench
========================================

Name: mem_trace_log_arbiter

Overview:
- Shares one memory-trace logger port between NUM_SRC trace producers, e.g. request and response taps of several cores.
- Each source gets a one-entry holding buffer. The block timestamps each beat on acceptance, arbitrates round-robin among held beats, and presents one registered beat at a time.
- The output carries the source id and the original cycle stamp, so the logger records true issue time even when the port is backpressured.

Parameters:
- NUM_SRC, 4, number of requesting sources (>=2)
- NUM_LANES, 4, lanes per beat
- DATA_WIDTH, 64, width of address, data and cycle stamp
- LOGSIZE_WIDTH, 32, per-lane size field width
- SRC_W, $clog2(NUM_SRC), source id width

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_valid  in  NUM_SRC  per-source beat valid
- in_ready  out  NUM_SRC  per-source beat accept
- in_lane_valid  in  NUM_SRC*NUM_LANES  lane valids; source s at [s*NUM_LANES +: NUM_LANES], lane 0 at LSB
- in_address  in  NUM_SRC*NUM_LANES*DATA_WIDTH  per-lane address, same packing
- in_is_store  in  NUM_SRC*NUM_LANES  per-lane store flag
- in_size  in  NUM_SRC*NUM_LANES*LOGSIZE_WIDTH  per-lane log2 size
- in_data  in  NUM_SRC*NUM_LANES*DATA_WIDTH  per-lane data
- out_valid  out  1  output beat valid
- out_ready  in  1  logger ready
- out_src  out  SRC_W  granted source id
- out_cycle  out  DATA_WIDTH  cycle stamp captured at acceptance
- out_lane_valid  out  NUM_LANES  lane valids of output beat
- out_address  out  NUM_LANES*DATA_WIDTH  per-lane address
- out_is_store  out  NUM_LANES  per-lane store flag
- out_size  out  NUM_LANES*LOGSIZE_WIDTH  per-lane size
- out_data  out  NUM_LANES*DATA_WIDTH  per-lane data
- stall_cycles  out  32  count of cycles with out_valid && !out_ready

Behaviour:
- Reset (synchronous, active-high): held[] = 0; out_valid = 0; all out_* payload = 0; cycle_counter = 0; stall_cycles = 0; last_grant = NUM_SRC-1, so source 0 has first priority.
- cycle_counter: DATA_WIDTH bits, +1 every non-reset cycle, wraps modulo 2^DATA_WIDTH.
- Output load: adv = !out_valid || out_ready.
- Grant: when adv && any held, grant the first held source searching from (last_grant+1) mod NUM_SRC upward with wrap.
  - On grant, copy the held payload, src id and stamp into the out_* registers; set out_valid = 1; clear held[g]; last_grant <= g.
- No grant: when adv and nothing held, out_valid <= 0 at the clock edge. When !adv, the out_* registers stay stable.
- in_ready[s] = !held[s] || (grant to s this cycle). This is combinational from registers and out_ready, and sustains one beat per cycle per source.
- Capture: on in_valid[s] && in_ready[s] with any lane valid, set held[s] = 1 and capture the payload with stamp = current cycle_counter.
- Empty beats: a beat with all lane valids 0 is accepted (ready as above) and discarded. It never reaches the output.
- Simultaneous events: refill of source s in its grant cycle is legal. The old beat moves to the output and the new beat is held, with no bubble.
- Latency: minimum 1 cycle from in acceptance to out_valid.
- Ordering: per-source order is preserved. Across sources, order follows round-robin, not timestamp.
- Fairness: with all sources continuously held, each is granted exactly once per NUM_SRC output beats.
- stall_cycles: +1 each cycle out_valid && !out_ready; saturates at 2^32-1; never resets except on reset.
- Reset mid-operation: held and pending output beats are dropped silently, and the stamp counter restarts at 0.

Test Plan:
- Single source:
  - Reset, then src2 presents 1 beat at cycle_counter=5 (lanes 0b0011, addr0=0x1000, addr1=0x1008), out_ready=1.
  - Required: the next cycle shows out_valid=1, out_src=2, out_cycle=5, out_lane_valid=0b0011, matching addresses.
- All sources contending:
  - All 4 sources valid every cycle, out_ready=1.
  - Required: out_src sequence 0,1,2,3,0,1,… with out_valid=1 every cycle; each in_ready=1 on its grant cycle.
- Backpressure:
  - out_ready=0 for 10 cycles while src0 and src1 each send one beat.
  - Required: out_* stable throughout; in_ready[0] and in_ready[1] are 0 after capture; stall_cycles=10.
  - Then out_ready=1: beats drain in two cycles with their original stamps.
- Empty beat:
  - src1 in_valid=1, in_lane_valid=0.
  - Required: in_ready[1]=1, no out_valid, held[1] stays 0.
- Refill in grant cycle:
  - src3 streams stamps 7,8,9 back-to-back as the only source.
  - Required: out_cycle=7,8,9 on consecutive cycles.
- Reset mid-operation:
  - Assert reset with out_valid=1 and 2 sources held.
  - Required: next cycle out_valid=0, in_ready all 1, stall_cycles=0; the first post-reset grant goes to the lowest-index valid source.

Source files
------------

// File: rtl/mem_trace_log_arbiter.sv
// Shares one memory-trace logger port among NUM_SRC producers. Each source has a one-entry
// holding buffer, beats are stamped on acceptance, granted round-robin and presented registered.
module mem_trace_log_arbiter #(
   parameter int unsigned NUM_SRC       = 4,
   parameter int unsigned NUM_LANES     = 4,
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned LOGSIZE_WIDTH = 32,
   parameter int unsigned SRC_W         = $clog2(NUM_SRC)
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic [NUM_SRC-1:0]                          in_valid,
   output logic [NUM_SRC-1:0]                          in_ready,
   input  logic [NUM_SRC*NUM_LANES-1:0]                in_lane_valid,
   input  logic [NUM_SRC*NUM_LANES*DATA_WIDTH-1:0]     in_address,
   input  logic [NUM_SRC*NUM_LANES-1:0]                in_is_store,
   input  logic [NUM_SRC*NUM_LANES*LOGSIZE_WIDTH-1:0]  in_size,
   input  logic [NUM_SRC*NUM_LANES*DATA_WIDTH-1:0]     in_data,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [SRC_W-1:0]                            out_src,
   output logic [DATA_WIDTH-1:0]                       out_cycle,
   output logic [NUM_LANES-1:0]                        out_lane_valid,
   output logic [NUM_LANES*DATA_WIDTH-1:0]             out_address,
   output logic [NUM_LANES-1:0]                        out_is_store,
   output logic [NUM_LANES*LOGSIZE_WIDTH-1:0]          out_size,
   output logic [NUM_LANES*DATA_WIDTH-1:0]             out_data,
   output logic [31:0]                                 stall_cycles
);

   localparam int unsigned WIDE_W = NUM_LANES * DATA_WIDTH;
   localparam int unsigned SIZE_W = NUM_LANES * LOGSIZE_WIDTH;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] cycle;
      logic [NUM_LANES-1:0]  lane_valid;
      logic [WIDE_W-1:0]     address;
      logic [NUM_LANES-1:0]  is_store;
      logic [SIZE_W-1:0]     size;
      logic [WIDE_W-1:0]     data;
   } beat_t;

   logic [DATA_WIDTH-1:0] r_cycle;
   logic [SRC_W-1:0]      r_last_grant;
   logic                  r_held [NUM_SRC];
   beat_t                 r_buf  [NUM_SRC];
   beat_t                 r_out;
   logic                  r_out_valid;
   logic [SRC_W-1:0]      r_out_src;
   logic [31:0]           r_stall;

   beat_t                 w_in_beat [NUM_SRC];
   logic [NUM_SRC-1:0]    w_accept;
   logic [NUM_SRC-1:0]    w_grant_me;
   logic                  w_adv;
   logic                  w_grant_vld;
   logic [SRC_W-1:0]      w_grant;
   int unsigned           w_cand;

   assign w_adv = !r_out_valid || out_ready;

   // Round-robin search starting just after the last granted source.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant     = '0;
      w_cand      = 0;
      if (w_adv) begin
         for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            w_cand = (32'(r_last_grant) + i) % NUM_SRC;
            if (!w_grant_vld && r_held[SRC_W'(w_cand)]) begin
               w_grant_vld = 1'b1;
               w_grant     = SRC_W'(w_cand);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      localparam int unsigned LANE_LO = g * NUM_LANES;
      localparam int unsigned WIDE_LO = g * WIDE_W;
      localparam int unsigned SIZE_LO = g * SIZE_W;

      assign w_in_beat[g] = '{
         cycle:      r_cycle,
         lane_valid: in_lane_valid[LANE_LO +: NUM_LANES],
         address:    in_address[WIDE_LO +: WIDE_W],
         is_store:   in_is_store[LANE_LO +: NUM_LANES],
         size:       in_size[SIZE_LO +: SIZE_W],
         data:       in_data[WIDE_LO +: WIDE_W]
      };

      assign w_grant_me[g] = w_grant_vld && (w_grant == SRC_W'(g));
      assign in_ready[g]   = !r_held[g] || w_grant_me[g];
      // Beats with no valid lane are accepted and dropped.
      assign w_accept[g]   = in_valid[g] && in_ready[g] && (|in_lane_valid[LANE_LO +: NUM_LANES]);

      // Refill wins over the grant clear so a source can stream one beat per cycle.
      always_ff @(posedge clock) begin
         if (reset) begin
            r_held[g] <= 1'b0;
            r_buf[g]  <= '0;
         end else if (w_accept[g]) begin
            r_held[g] <= 1'b1;
            r_buf[g]  <= w_in_beat[g];
         end else if (w_grant_me[g]) begin
            r_held[g] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cycle      <= '0;
         r_last_grant <= SRC_W'(NUM_SRC - 1);
         r_out        <= '0;
         r_out_valid  <= 1'b0;
         r_out_src    <= '0;
         r_stall      <= '0;
      end else begin
         r_cycle <= r_cycle + DATA_WIDTH'(1);
         if (w_adv) begin
            if (w_grant_vld) begin
               r_out_valid  <= 1'b1;
               r_out_src    <= w_grant;
               r_out        <= r_buf[w_grant];
               r_last_grant <= w_grant;
            end else begin
               r_out_valid  <= 1'b0;
            end
         end
         if (r_out_valid && !out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
         end
      end
   end

   assign out_valid      = r_out_valid;
   assign out_src        = r_out_src;
   assign out_cycle      = r_out.cycle;
   assign out_lane_valid = r_out.lane_valid;
   assign out_address    = r_out.address;
   assign out_is_store   = r_out.is_store;
   assign out_size       = r_out.size;
   assign out_data       = r_out.data;
   assign stall_cycles   = r_stall;

endmodule

// File: tb/tb_mem_trace_log_arbiter.sv
// Directed bench for mem_trace_log_arbiter: reset, single source, contention,
// backpressure, empty beats, back-to-back refill and mid-run reset.
module tb_mem_trace_log_arbiter;

   localparam int unsigned NS = 4;
   localparam int unsigned NL = 4;
   localparam int unsigned DW = 64;
   localparam int unsigned SW = 32;

   logic                clock;
   logic                reset;
   logic [NS-1:0]       in_valid;
   logic [NS-1:0]       in_ready;
   logic [NS*NL-1:0]    in_lane_valid;
   logic [NS*NL*DW-1:0] in_address;
   logic [NS*NL-1:0]    in_is_store;
   logic [NS*NL*SW-1:0] in_size;
   logic [NS*NL*DW-1:0] in_data;
   logic                out_valid;
   logic                out_ready;
   logic [1:0]          out_src;
   logic [DW-1:0]       out_cycle;
   logic [NL-1:0]       out_lane_valid;
   logic [NL*DW-1:0]    out_address;
   logic [NL-1:0]       out_is_store;
   logic [NL*SW-1:0]    out_size;
   logic [NL*DW-1:0]    out_data;
   logic [31:0]         stall_cycles;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   mem_trace_log_arbiter #(
      .NUM_SRC(NS), .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(SW), .SRC_W(2)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_lane_valid(in_lane_valid),
      .in_address(in_address), .in_is_store(in_is_store), .in_size(in_size), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .out_cycle(out_cycle),
      .out_lane_valid(out_lane_valid), .out_address(out_address), .out_is_store(out_is_store),
      .out_size(out_size), .out_data(out_data), .stall_cycles(stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Lane l of source s: address base+8*l, data base^l, size l.
   task automatic set_beat(input int s, input logic [NL-1:0] lanes, input logic [63:0] base);
      for (int l = 0; l < NL; l++) begin
         in_lane_valid[s*NL + l]           = lanes[l];
         in_is_store[s*NL + l]             = lanes[l];
         in_address[(s*NL + l)*DW +: DW]   = lanes[l] ? base + 64'(8*l) : 64'h0;
         in_data[(s*NL + l)*DW +: DW]      = base ^ 64'(l);
         in_size[(s*NL + l)*SW +: SW]      = 32'(l);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = '0;
      step();
      reset    = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = '0; in_lane_valid = '0; in_address = '0;
      in_is_store = '0; in_size = '0; in_data = '0; out_ready = 1'b1;
      step(); step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'hF);
      chk("rst_stall", 64'(stall_cycles), 64'd0);
      chk("rst_out_cycle", out_cycle, 64'd0);
      reset = 1'b0;

      // Single source: src2 beat accepted while the stamp counter reads 5.
      repeat (5) step();
      set_beat(2, 4'b0011, 64'h1000);
      in_valid = 4'b0100;
      step();
      in_valid = '0;
      chk("s1_latency", 64'(out_valid), 64'd0);
      step();
      chk("s1_out_valid", 64'(out_valid), 64'd1);
      chk("s1_out_src", 64'(out_src), 64'd2);
      chk("s1_out_cycle", out_cycle, 64'd5);
      chk("s1_lanes", 64'(out_lane_valid), 64'h3);
      chk("s1_addr0", out_address[63:0], 64'h1000);
      chk("s1_addr1", out_address[127:64], 64'h1008);
      chk("s1_store", 64'(out_is_store), 64'h3);
      chk("s1_size1", 64'(out_size[63:32]), 64'd1);
      chk("s1_data1", out_data[127:64], 64'h1001);

      // All four sources contending every cycle.
      do_reset();
      for (int s = 0; s < NS; s++) set_beat(s, 4'b0001, 64'(s) << 12);
      in_valid = 4'hF;
      #1;
      chk("s2_rdy_first", 64'(in_ready), 64'hF);
      step();
      for (int k = 0; k < 8; k++) begin
         chk("s2_rdy_grant", 64'(in_ready), 64'(4'b0001 << (k % 4)));
         step();
         chk("s2_out_valid", 64'(out_valid), 64'd1);
         chk("s2_out_src", 64'(out_src), 64'(k % 4));
         chk("s2_out_addr", out_address[63:0], 64'(k % 4) << 12);
      end
      in_valid = '0;

      // Backpressure: src2 parks at the output, src0/src1 sit in their buffers.
      do_reset();
      out_ready = 1'b0;
      set_beat(2, 4'b1111, 64'h2000);
      in_valid = 4'b0100;
      step();
      set_beat(0, 4'b0001, 64'h3000);
      set_beat(1, 4'b0010, 64'h4000);
      in_valid = 4'b0011;
      step();
      in_valid = '0;
      chk("s3_rdy_held", 64'(in_ready[1:0]), 64'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("s3_hold_valid", 64'(out_valid), 64'd1);
         chk("s3_hold_src", 64'(out_src), 64'd2);
         chk("s3_hold_cycle", out_cycle, 64'd0);
         chk("s3_hold_addr", out_address[63:0], 64'h2000);
      end
      chk("s3_rdy_still", 64'(in_ready[1:0]), 64'd0);
      chk("s3_stall10", 64'(stall_cycles), 64'd10);
      out_ready = 1'b1;
      step();
      chk("s3_drain0_src", 64'(out_src), 64'd0);
      chk("s3_drain0_cycle", out_cycle, 64'd1);
      chk("s3_drain0_addr", out_address[63:0], 64'h3000);
      step();
      chk("s3_drain1_src", 64'(out_src), 64'd1);
      chk("s3_drain1_cycle", out_cycle, 64'd1);
      chk("s3_drain1_addr", out_address[127:64], 64'h4008);
      step();
      chk("s3_drained", 64'(out_valid), 64'd0);
      chk("s3_stall_keep", 64'(stall_cycles), 64'd10);

      // Empty beat is accepted and dropped.
      do_reset();
      set_beat(1, 4'b0000, 64'h5000);
      in_valid = 4'b0010;
      #1;
      chk("s4_rdy", 64'(in_ready[1]), 64'd1);
      step();
      chk("s4_no_out", 64'(out_valid), 64'd0);
      chk("s4_not_held", 64'(in_ready), 64'hF);
      step();
      in_valid = '0;
      chk("s4_no_out2", 64'(out_valid), 64'd0);

      // src3 streams stamps 7,8,9 back-to-back.
      do_reset();
      repeat (7) step();
      set_beat(3, 4'b0001, 64'h7000);
      in_valid = 4'b1000;
      step();
      chk("s5_rdy_a", 64'(in_ready[3]), 64'd1);
      set_beat(3, 4'b0001, 64'h8000);
      step();
      chk("s5_cycle7", out_cycle, 64'd7);
      chk("s5_addr7", out_address[63:0], 64'h7000);
      chk("s5_rdy_b", 64'(in_ready[3]), 64'd1);
      set_beat(3, 4'b0001, 64'h9000);
      step();
      in_valid = '0;
      chk("s5_valid8", 64'(out_valid), 64'd1);
      chk("s5_cycle8", out_cycle, 64'd8);
      step();
      chk("s5_valid9", 64'(out_valid), 64'd1);
      chk("s5_cycle9", out_cycle, 64'd9);
      chk("s5_addr9", out_address[63:0], 64'h9000);
      step();
      chk("s5_idle", 64'(out_valid), 64'd0);

      // Reset with an output beat pending and two sources held.
      do_reset();
      out_ready = 1'b0;
      set_beat(0, 4'b0001, 64'hA000);
      in_valid = 4'b0001;
      step();
      set_beat(1, 4'b0001, 64'hB000);
      set_beat(2, 4'b0001, 64'hC000);
      in_valid = 4'b0110;
      step();
      in_valid = '0;
      step();
      chk("s6_pre_valid", 64'(out_valid), 64'd1);
      chk("s6_pre_stall", 64'(stall_cycles), 64'd1);
      chk("s6_pre_rdy", 64'(in_ready), 64'h9);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("s6_rst_valid", 64'(out_valid), 64'd0);
      chk("s6_rst_rdy", 64'(in_ready), 64'hF);
      chk("s6_rst_stall", 64'(stall_cycles), 64'd0);
      out_ready = 1'b1;
      in_valid  = 4'b0110;
      step();
      in_valid = '0;
      step();
      chk("s6_first_valid", 64'(out_valid), 64'd1);
      chk("s6_first_src", 64'(out_src), 64'd1);
      chk("s6_first_cycle", out_cycle, 64'd0);
      step();
      chk("s6_second_src", 64'(out_src), 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
